touch_coord_filter: RTL and testbench
=====================================

// Module: touch_coord_filter
// PURPOSE
//  Upstream conditioning stage for the LCD touch path: takes raw touch-controller samples
//  (one x/y pair per smp_valid pulse), clamps them to the panel area, box-averages
//  2**AVG_LOG2 consecutive touched samples, and debounces release.
//  Produces the packed 32-bit coordinate word {x[15:0], y[15:0]} that the character
//  display top converts to BCD and draws. Output holds its last value between updates.
// PARAMETERS
//  AVG_LOG2     2    log2 of samples averaged per output (1..4)
//  H_MAX        800  panel width; x clamped to H_MAX-1
//  V_MAX        480  panel height; y clamped to V_MAX-1
//  RELEASE_CNT  3    consecutive untouched samples needed to declare release (>=1)
// PORTS
//  sys_clk       in   1   system clock; all logic on rising edge
//  sys_rst       in   1   synchronous, active-high reset
//  smp_valid     in   1   one-cycle strobe: smp_* fields valid this cycle
//  smp_touch     in   1   controller reports a finger present in this sample
//  smp_x         in   16  raw x coordinate
//  smp_y         in   16  raw y coordinate
//  data          out  32  {avg_x, avg_y}; held between updates
//  data_valid    out  1   one-cycle pulse when data is updated
//  touch_active  out  1   1 while a debounced touch is in progress
// BEHAVIOUR
//  Reset: data=0, data_valid=0, touch_active=0, accumulators/counters=0, state=IDLE.
//  Only cycles with smp_valid=1 are acted on; all other cycles leave state unchanged.
//  Clamp (combinational, pre-accumulate): x' = (smp_x >= H_MAX) ? H_MAX-1 : smp_x;
//    y' likewise with V_MAX. Accumulators are 16+AVG_LOG2 bits; never overflow.
//  States:
//   IDLE : touch_active=0. Valid & touch -> acc_x=x', acc_y=y', smp_cnt=1, rel_cnt=0,
//          go ACCUM. Valid & !touch -> stay.
//   ACCUM: valid & touch -> rel_cnt=0; acc += clamped sample; smp_cnt++.
//          When this sample makes smp_cnt == 2**AVG_LOG2: next edge data <=
//          {acc_x_sum>>AVG_LOG2, acc_y_sum>>AVG_LOG2} (truncating), data_valid=1 for that
//          one cycle, touch_active=1, acc and smp_cnt cleared; stay ACCUM.
//          valid & !touch -> sample not accumulated; rel_cnt++. When rel_cnt reaches
//          RELEASE_CNT: go IDLE, touch_active=0, partial accumulation discarded,
//          data NOT cleared. A touched sample before that resets rel_cnt and keeps acc.
//  Latency: data/data_valid update on the edge after the completing sample's strobe
//    (1 cycle). touch_active rises with the first data_valid, falls on the edge after
//    the RELEASE_CNT-th untouched strobe.
//  Back-to-back smp_valid on consecutive cycles supported at full rate.
//  sys_rst asserted mid-average: all state returns to reset values next edge;
//    no data_valid is emitted for the partial batch.
//  data upper half = x, lower half = y (matches the display top's split).
// STRUCTURE
//  Shared package touch_pkg: default H_MAX/V_MAX, state enum {IDLE, ACCUM},
//    COORD_W=16 constant, coordinate packing helper.
//  One sub-module: touch_axis_acc (clamp + accumulate + divide for one axis,
//    params MAX and AVG_LOG2), instantiated twice (x, y); FSM and
//    counters stay in this module.
// TESTING
//  1) Reset, then 4 touched strobes x=100,102,104,106 y=50 -> one data_valid,
//     data=32'h0067_0032 (103,50), touch_active=1, exactly 1 cycle after 4th strobe.
//  2) Touched strobe x=900,y=600 x4 -> data={799,479}=32'h031F_01DF (clamping).
//  3) Active touch, 2 untouched strobes then touched -> touch_active stays 1,
//     rel_cnt resets; 3 untouched strobes -> touch_active=0, data unchanged.
//  4) 3 touched strobes then sys_rst=1 for 1 cycle, then 1 touched strobe ->
//     no data_valid; all outputs 0 after reset; new batch needs 4 fresh strobes.
//  5) 8 consecutive-cycle strobes x=0..7,y=7..0 -> two data_valid pulses,
//     data=32'h0001_0005 then 32'h0005_0001 (truncating division).
//  6) smp_touch=0 strobes only from IDLE -> no data_valid, touch_active stays 0.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types and constants for the touch coordinate conditioning path.
package touch_pkg;

  localparam int unsigned COORD_W   = 16;
  localparam int unsigned H_MAX_DEF = 800;
  localparam int unsigned V_MAX_DEF = 480;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  // Upper half carries x, lower half y, as the display top splits it.
  function automatic logic [2*COORD_W-1:0] pack_coord(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/touch_coord_filter_if.sv
// Sample input and filtered coordinate output bundle of the touch filter.
interface touch_coord_filter_if;
  import touch_pkg::*;

  logic                   smp_valid;
  logic                   smp_touch;
  logic [COORD_W-1:0]     smp_x;
  logic [COORD_W-1:0]     smp_y;
  logic [2*COORD_W-1:0]   data;
  logic                   data_valid;
  logic                   touch_active;

  modport master (
    output smp_valid, smp_touch, smp_x, smp_y,
    input  data, data_valid, touch_active
  );

  modport slave (
    input  smp_valid, smp_touch, smp_x, smp_y,
    output data, data_valid, touch_active
  );

endinterface

// File: rtl/touch_axis_acc.sv
// One coordinate axis: clamp to the panel edge, accumulate, and divide by 2**AVG_LOG2.
module touch_axis_acc
  import touch_pkg::*;
#(
  parameter int unsigned MAX      = H_MAX_DEF,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] smp,
  input  logic               load,
  input  logic               add,
  input  logic               clear,
  output logic [COORD_W-1:0] avg
);

  localparam int unsigned        ACC_W = COORD_W + AVG_LOG2;
  localparam logic [COORD_W-1:0] LIMIT = COORD_W'(MAX - 1);

  logic [COORD_W-1:0] clamped;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [ACC_W-1:0]   sum;

  always_comb clamped = (smp > LIMIT) ? LIMIT : smp;

  // Sum includes the current sample so the completing strobe is averaged in directly.
  assign sum = acc_q + ACC_W'(clamped);
  assign avg = sum[AVG_LOG2 +: COORD_W];

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = ACC_W'(clamped);
    end else if (add) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/touch_coord_filter.sv
// Touch sample conditioning: clamp, box-average 2**AVG_LOG2 touched samples, debounce release.
module touch_coord_filter
  import touch_pkg::*;
#(
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned H_MAX       = H_MAX_DEF,
  parameter int unsigned V_MAX       = V_MAX_DEF,
  parameter int unsigned RELEASE_CNT = 3
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  touch_coord_filter_if.slave bus
);

  localparam int unsigned    CNT_W    = AVG_LOG2 + 1;
  localparam int unsigned    REL_W    = (RELEASE_CNT > 1) ? $clog2(RELEASE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CNT - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     smp_cnt_q, smp_cnt_d;
  logic [REL_W-1:0]     rel_cnt_q, rel_cnt_d;
  logic [2*COORD_W-1:0] data_q;
  logic                 data_valid_q;
  logic                 touch_active_q, touch_active_d;
  logic                 touched, untouched, batch_done, rel_done;
  logic                 acc_load, acc_add, acc_clear, emit;
  logic [COORD_W-1:0]   avg_x, avg_y;

  assign touched    = bus.smp_valid & bus.smp_touch;
  assign untouched  = bus.smp_valid & ~bus.smp_touch;
  assign batch_done = (smp_cnt_q == CNT_LAST);
  assign rel_done   = (rel_cnt_q == REL_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (touched) state_d = ACCUM;
      ACCUM: if (untouched && rel_done) state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_load       = 1'b0;
    acc_add        = 1'b0;
    acc_clear      = 1'b0;
    emit           = 1'b0;
    smp_cnt_d      = smp_cnt_q;
    rel_cnt_d      = rel_cnt_q;
    touch_active_d = touch_active_q;
    unique case (state_q)
      IDLE: begin
        if (touched) begin
          acc_load  = 1'b1;
          smp_cnt_d = CNT_W'(1);
          rel_cnt_d = '0;
        end
      end
      ACCUM: begin
        if (touched) begin
          rel_cnt_d = '0;
          if (batch_done) begin
            emit           = 1'b1;
            acc_clear      = 1'b1;
            smp_cnt_d      = '0;
            touch_active_d = 1'b1;
          end else begin
            acc_add   = 1'b1;
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
          end
        end else if (untouched) begin
          if (rel_done) begin
            // Release: partial batch dropped, last published coordinate kept.
            acc_clear      = 1'b1;
            smp_cnt_d      = '0;
            rel_cnt_d      = '0;
            touch_active_d = 1'b0;
          end else begin
            rel_cnt_d = rel_cnt_q + REL_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      smp_cnt_q      <= '0;
      rel_cnt_q      <= '0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      touch_active_q <= 1'b0;
    end else begin
      smp_cnt_q      <= smp_cnt_d;
      rel_cnt_q      <= rel_cnt_d;
      data_valid_q   <= emit;
      touch_active_q <= touch_active_d;
      if (emit) data_q <= pack_coord(avg_x, avg_y);
    end
  end

  touch_axis_acc #(
    .MAX      (H_MAX),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc_x (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .smp   (bus.smp_x),
    .load  (acc_load),
    .add   (acc_add),
    .clear (acc_clear),
    .avg   (avg_x)
  );

  touch_axis_acc #(
    .MAX      (V_MAX),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc_y (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .smp   (bus.smp_y),
    .load  (acc_load),
    .add   (acc_add),
    .clear (acc_clear),
    .avg   (avg_y)
  );

  assign bus.data         = data_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.touch_active = touch_active_q;

endmodule

// File: tb/tb_touch_coord_filter.sv
// Directed bench for touch_coord_filter: averaging, clamping, release debounce, reset.
module tb_touch_coord_filter;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   n_checks = 0;
  int   n_errors = 0;

  touch_coord_filter_if bus ();

  touch_coord_filter #(
    .AVG_LOG2    (2),
    .H_MAX       (800),
    .V_MAX       (480),
    .RELEASE_CNT (3)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change just after a falling edge; outputs are read at the next falling edge.
  task automatic step(input logic v, input logic t, input int x, input int y);
    bus.smp_valid = v;
    bus.smp_touch = t;
    bus.smp_x     = 16'(x);
    bus.smp_y     = 16'(y);
    @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input logic dv,
                           input logic ta);
    check({tag, ".data"}, bus.data, d);
    check({tag, ".data_valid"}, {31'd0, bus.data_valid}, {31'd0, dv});
    check({tag, ".touch_active"}, {31'd0, bus.touch_active}, {31'd0, ta});
  endtask

  initial begin
    sys_rst = 1'b1;
    bus.smp_valid = 1'b0;
    bus.smp_touch = 1'b0;
    bus.smp_x     = '0;
    bus.smp_y     = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check_out("reset", 32'h0, 1'b0, 1'b0);
    sys_rst = 1'b0;

    // 1) average of 100,102,104,106 / 50; non-valid cycles in between are ignored
    step(1, 1, 100, 50);
    check_out("t1.s1", 32'h0, 1'b0, 1'b0);
    step(1, 1, 102, 50);
    step(0, 1, 999, 999);
    step(0, 1, 999, 999);
    check_out("t1.gap", 32'h0, 1'b0, 1'b0);
    step(1, 1, 104, 50);
    check_out("t1.s3", 32'h0, 1'b0, 1'b0);
    step(1, 1, 106, 50);
    check_out("t1.s4", 32'h0067_0032, 1'b1, 1'b1);
    step(0, 0, 0, 0);
    check_out("t1.hold", 32'h0067_0032, 1'b0, 1'b1);

    // 2) clamping to 799/479
    for (int i = 0; i < 3; i++) step(1, 1, 900, 600);
    check_out("t2.s3", 32'h0067_0032, 1'b0, 1'b1);
    step(1, 1, 900, 600);
    check_out("t2.s4", 32'h031F_01DF, 1'b1, 1'b1);

    // 3) release debounce; a touched strobe restarts the untouched count
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_out("t3.two_rel", 32'h031F_01DF, 1'b0, 1'b1);
    step(1, 1, 10, 20);
    check_out("t3.retouch", 32'h031F_01DF, 1'b0, 1'b1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_out("t3.two_more", 32'h031F_01DF, 1'b0, 1'b1);
    step(1, 0, 0, 0);
    check_out("t3.release", 32'h031F_01DF, 1'b0, 1'b0);

    // 4) reset mid-batch drops the partial sum and clears outputs
    for (int i = 0; i < 3; i++) step(1, 1, 200, 100);
    check_out("t4.partial", 32'h031F_01DF, 1'b0, 1'b0);
    sys_rst = 1'b1;
    step(0, 0, 0, 0);
    check_out("t4.reset", 32'h0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    step(1, 1, 40, 8);
    check_out("t4.f1", 32'h0, 1'b0, 1'b0);
    step(1, 1, 40, 8);
    step(1, 1, 40, 8);
    check_out("t4.f3", 32'h0, 1'b0, 1'b0);
    step(1, 1, 40, 8);
    check_out("t4.f4", 32'h0028_0008, 1'b1, 1'b1);

    // 5) back-to-back strobes, truncating division
    for (int i = 0; i < 8; i++) begin
      step(1, 1, i, 7 - i);
      if (i == 3) check_out("t5.first", 32'h0001_0005, 1'b1, 1'b1);
      if (i == 4) check_out("t5.between", 32'h0001_0005, 1'b0, 1'b1);
      if (i == 7) check_out("t5.second", 32'h0005_0001, 1'b1, 1'b1);
    end

    // 6) untouched strobes only, from IDLE
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check_out("t6.release", 32'h0005_0001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 300, 300);
      check_out("t6.idle", 32'h0005_0001, 1'b0, 1'b0);
    end
    step(0, 0, 0, 0);
    check_out("t6.end", 32'h0005_0001, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
